// File: rtl/bht_branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch history table predictor.
// The master modport is the pipeline; the slave modport is the predictor.
interface bht_branch_predictor_if;
    logic [31:0] current_pc_i;
    logic        is_backward_branch_i;
    logic        have_branch_history_i;
    logic [31:0] branch_history_address_i;
    logic        branch_history_decision_i;
    logic        branch_predicted_o;

    modport master (
        output current_pc_i,
        output is_backward_branch_i,
        output have_branch_history_i,
        output branch_history_address_i,
        output branch_history_decision_i,
        input  branch_predicted_o
    );

    modport slave (
        input  current_pc_i,
        input  is_backward_branch_i,
        input  have_branch_history_i,
        input  branch_history_address_i,
        input  branch_history_decision_i,
        output branch_predicted_o
    );
endinterface

// File: rtl/bht_branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters with valid bits; untrained
// entries fall back to static backward-taken / forward-not-taken prediction.
module bht_branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    bht_branch_predictor_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } entry_t;

    entry_t                table_q [ENTRIES];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    entry_t                rd_entry;
    entry_t                wr_entry;
    entry_t                wr_next;
    logic                  unused_addr_bits;

    assign rd_idx = bus.current_pc_i[INDEX_BITS+1:2];
    assign wr_idx = bus.branch_history_address_i[INDEX_BITS+1:2];

    // Word offset and bits above the index do not participate (no tags).
    assign unused_addr_bits = ^{bus.current_pc_i[31:INDEX_BITS+2], bus.current_pc_i[1:0],
                                bus.branch_history_address_i[31:INDEX_BITS+2],
                                bus.branch_history_address_i[1:0]};

    assign rd_entry = table_q[rd_idx];
    assign wr_entry = table_q[wr_idx];

    // Reads the pre-update entry, so a same-cycle write to this index is not bypassed.
    assign bus.branch_predicted_o = rd_entry.valid ? rd_entry.ctr[1] : bus.is_backward_branch_i;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        wr_next = wr_entry;
        if (!wr_entry.valid) begin
            wr_next.valid = 1'b1;
            wr_next.ctr   = bus.branch_history_decision_i ? 2'b10 : 2'b01;
        end else if (bus.branch_history_decision_i) begin
            if (wr_entry.ctr != 2'b11) wr_next.ctr = wr_entry.ctr + 2'd1;
        end else begin
            if (wr_entry.ctr != 2'b00) wr_next.ctr = wr_entry.ctr - 2'd1;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        entry_t entry_q;
        logic   wr_en;

        assign wr_en = bus.have_branch_history_i && (wr_idx == INDEX_BITS'(i));

        // NOTE: the table is a register file that must be cleared by reset, since a
        // stale valid bit would override the static fallback; state uses non-blocking <=.
        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                entry_q <= '{valid: 1'b0, ctr: 2'b01};
            end else if (wr_en) begin
                entry_q <= wr_next;
            end
        end

        assign table_q[i] = entry_q;
    end
endmodule

// File: tb/tb_bht_branch_predictor.sv
// Self-checking bench: directed training table, hand-written corner sequences and
// randomized traffic against an array-based counter model.
module tb_bht_branch_predictor;
    localparam int IB      = 6;
    localparam int ENTRIES = 1 << IB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bht_branch_predictor_if bus ();

    bht_branch_predictor #(.INDEX_BITS(IB)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: per-index valid flag and integer counter 0..3.
    bit m_valid [ENTRIES];
    int m_ctr   [ENTRIES];

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic logic model_pred(logic [31:0] pc, logic bwd);
        int k = idx_of(pc);
        if (!m_valid[k]) return bwd;
        return (m_ctr[k] >= 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_update(logic [31:0] a, logic taken);
        int k = idx_of(a);
        if (!m_valid[k]) begin
            m_valid[k] = 1'b1;
            m_ctr[k]   = taken ? 2 : 1;
        end else if (taken) begin
            m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
        end else begin
            m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 1;
        end
    endtask

    task automatic check(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic probe(string name, logic [31:0] pc, logic bwd, logic exp);
        bus.current_pc_i         = pc;
        bus.is_backward_branch_i = bwd;
        #1;
        check(name, bus.branch_predicted_o, exp);
    endtask

    // Reports one resolved branch across the next rising edge; leaves time at edge+1.
    task automatic report(logic [31:0] addr, logic taken);
        bus.have_branch_history_i     = 1'b1;
        bus.branch_history_address_i  = addr;
        bus.branch_history_decision_i = taken;
        @(posedge clk);
        #1;
        bus.have_branch_history_i = 1'b0;
        model_update(addr, taken);
    endtask

    task automatic sweep(string name);
        for (int k = 0; k < ENTRIES; k++) begin
            for (int b = 0; b < 2; b++) begin
                probe(name, 32'(k * 4), b[0], model_pred(32'(k * 4), b[0]));
            end
        end
    endtask

    typedef struct {
        string       name;
        bit          have;
        logic [31:0] addr;
        logic        taken;
        logic [31:0] pc;
        logic        bwd;
        logic        exp;
    } vec_t;

    vec_t vecs [$];

    initial begin
        // Directed training table; expectations are hand-derived from the counter rules.
        vecs.push_back('{"first_taken_0x40",   1, 32'h40, 1'b1, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"first_nt_0x44",      1, 32'h44, 1'b0, 32'h44,  1'b1, 1'b0});
        vecs.push_back('{"sat_t1",             1, 32'h40, 1'b1, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"sat_t2",             1, 32'h40, 1'b1, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"sat_t3",             1, 32'h40, 1'b1, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"hyst_nt1",           1, 32'h40, 1'b0, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"hyst_nt2",           1, 32'h40, 1'b0, 32'h40,  1'b1, 1'b0});
        vecs.push_back('{"floor_nt3",          1, 32'h40, 1'b0, 32'h40,  1'b1, 1'b0});
        vecs.push_back('{"floor_nt4",          1, 32'h40, 1'b0, 32'h40,  1'b1, 1'b0});
        vecs.push_back('{"floor_nt5",          1, 32'h40, 1'b0, 32'h40,  1'b1, 1'b0});
        vecs.push_back('{"floor_nt6",          1, 32'h40, 1'b0, 32'h40,  1'b1, 1'b0});
        vecs.push_back('{"recover_t1",         1, 32'h40, 1'b1, 32'h40,  1'b1, 1'b0});
        vecs.push_back('{"recover_t2",         1, 32'h40, 1'b1, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"alias_train",        1, 32'h40, 1'b1, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"alias_0x140",        0, 32'h0,  1'b0, 32'h140, 1'b0, 1'b1});
        vecs.push_back('{"alias_0x43",         0, 32'h0,  1'b0, 32'h43,  1'b0, 1'b1});
        vecs.push_back('{"untrained_0x80_b0",  0, 32'h0,  1'b0, 32'h80,  1'b0, 1'b0});
        vecs.push_back('{"untrained_0x80_b1",  0, 32'h0,  1'b0, 32'h80,  1'b1, 1'b1});
        vecs.push_back('{"to_weak_nt1",        1, 32'h40, 1'b0, 32'h40,  1'b0, 1'b1});
        vecs.push_back('{"to_weak_nt2",        1, 32'h40, 1'b0, 32'h40,  1'b1, 1'b0});

        bus.current_pc_i              = '0;
        bus.is_backward_branch_i      = 1'b0;
        bus.have_branch_history_i     = 1'b0;
        bus.branch_history_address_i  = '0;
        bus.branch_history_decision_i = 1'b0;
        model_reset();

        // Reset held over two edges, released mid-cycle.
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        sweep("reset_fallback");

        foreach (vecs[i]) begin
            if (vecs[i].have) report(vecs[i].addr, vecs[i].taken);
            probe(vecs[i].name, vecs[i].pc, vecs[i].bwd, vecs[i].exp);
        end

        // Same-cycle read/write of a weak-NT entry: old value now, new value after the edge.
        bus.current_pc_i              = 32'h40;
        bus.is_backward_branch_i      = 1'b0;
        bus.have_branch_history_i     = 1'b1;
        bus.branch_history_address_i  = 32'h40;
        bus.branch_history_decision_i = 1'b1;
        #1;
        check("conflict_pre_edge", bus.branch_predicted_o, 1'b0);
        @(posedge clk);
        #1;
        bus.have_branch_history_i = 1'b0;
        model_update(32'h40, 1'b1);
        check("conflict_post_edge", bus.branch_predicted_o, 1'b1);

        // Randomized traffic; each prediction is checked before the edge that may update it.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] pc;
            logic        bwd;
            logic        have;
            logic [31:0] addr;
            logic        taken;
            pc    = $urandom;
            bwd   = 1'($urandom);
            have  = 1'($urandom_range(0, 2) != 0);
            addr  = $urandom;
            taken = 1'($urandom);
            bus.have_branch_history_i     = have;
            bus.branch_history_address_i  = addr;
            bus.branch_history_decision_i = taken;
            probe("random_pred", pc, bwd, model_pred(pc, bwd));
            @(posedge clk);
            #1;
            if (have) model_update(addr, taken);
        end
        bus.have_branch_history_i = 1'b0;
        sweep("random_final");

        // Idle cycles with random history fields must not change any entry.
        for (int c = 0; c < 20; c++) begin
            bus.branch_history_address_i  = $urandom;
            bus.branch_history_decision_i = 1'($urandom);
            @(posedge clk);
            #1;
        end
        sweep("idle_no_change");

        // Asynchronous reset asserted mid-cycle while an update is pending.
        bus.have_branch_history_i     = 1'b1;
        bus.branch_history_address_i  = 32'h40;
        bus.branch_history_decision_i = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        #1;
        bus.have_branch_history_i = 1'b0;
        sweep("reset_after_training");

        // Update on an edge where reset is still high must be dropped.
        bus.have_branch_history_i = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.have_branch_history_i = 1'b0;
        probe("update_during_reset_dropped", 32'h40, 1'b0, 1'b0);

        // First update after release is applied normally.
        report(32'h40, 1'b1);
        probe("update_after_release", 32'h40, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
